// File: rtl/tx_framer_qpsk.sv
// Burst framer for the transmit chain: preamble, 16-bit length header and payload
// bytes, QPSK-mapped and zero-stuffed to SPS samples per symbol for the DAC path.
module tx_framer_qpsk #(
  parameter int                   SPS       = 2,
  parameter int                   CLK_PER_S = 2,
  parameter int                   PRE_BITS  = 64,
  parameter logic [PRE_BITS-1:0]  PREAMBLE  = 64'hA5F0_3C96_0FF0_5AC3,
  parameter logic signed [15:0]   AMP       = 16'sd1448
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [15:0]        i_len,
  input  logic [7:0]         i_byte,
  input  logic               i_byte_vld,
  output logic               o_byte_rdy,
  output logic signed [15:0] o_toDAC_i,
  output logic signed [15:0] o_toDAC_q,
  output logic               o_toDAC_vld,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_underrun
);

  localparam int CW       = (CLK_PER_S > 1) ? $clog2(CLK_PER_S) : 1;
  localparam int SW       = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int PRE_SYMS = PRE_BITS / 2;

  typedef enum logic [1:0] {IDLE, PRE, HDR, PAY} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       clk_cnt;
  logic [SW-1:0]       smp_cnt;
  logic [17:0]         sym_cnt;
  logic [15:0]         len_reg;
  logic [15:0]         fetched;
  logic [PRE_BITS-1:0] pre_sr;
  logic [15:0]         hdr_sr;
  logic [7:0]          shreg;
  logic [7:0]          hold_data;
  logic                hold_vld;

  logic       busy, smp_end, sym_end, last_sym, need_load, underrun, done, take;
  logic [1:0] bits;

  always_comb begin
    busy     = (state != IDLE);
    smp_end  = (clk_cnt == CW'(CLK_PER_S - 1));
    sym_end  = smp_end && (smp_cnt == SW'(SPS - 1));
    last_sym = 1'b0;
    bits     = 2'b00;
    case (state)
      PRE: begin
        last_sym = (sym_cnt == 18'(PRE_SYMS - 1));
        bits     = pre_sr[PRE_BITS-1 -: 2];
      end
      HDR: begin
        last_sym = (sym_cnt == 18'd7);
        bits     = hdr_sr[15:14];
      end
      PAY: begin
        last_sym = (sym_cnt == ({len_reg, 2'b00} - 18'd1));
        bits     = shreg[7:6];
      end
      default: ;
    endcase
    // The first payload byte is loaded at the header's last symbol, so a missing
    // first byte aborts exactly like a missing byte later in the payload.
    need_load = sym_end && ((state == HDR && last_sym && len_reg != '0) ||
                            (state == PAY && sym_cnt[1:0] == 2'd3 && !last_sym));
    underrun  = need_load && !hold_vld;
    done      = sym_end && last_sym && (state == PAY || (state == HDR && len_reg == '0));
    o_byte_rdy = (state == HDR || state == PAY) && !hold_vld && (fetched < len_reg);
    take       = i_byte_vld && o_byte_rdy;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_start) state_nxt = PRE;
      PRE:  if (sym_end && last_sym) state_nxt = HDR;
      HDR:  if (done || underrun) state_nxt = IDLE;
            else if (sym_end && last_sym) state_nxt = PAY;
      PAY:  if (done || underrun) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      clk_cnt   <= '0;
      smp_cnt   <= '0;
      sym_cnt   <= '0;
      len_reg   <= '0;
      fetched   <= '0;
      pre_sr    <= '0;
      hdr_sr    <= '0;
      shreg     <= '0;
      hold_data <= '0;
      hold_vld  <= 1'b0;
    end else if (state == IDLE) begin
      clk_cnt <= '0;
      smp_cnt <= '0;
      sym_cnt <= '0;
      if (i_start) begin
        len_reg  <= i_len;
        hdr_sr   <= i_len;
        pre_sr   <= PREAMBLE;
        fetched  <= '0;
        hold_vld <= 1'b0;
      end
    end else begin
      clk_cnt <= smp_end ? '0 : clk_cnt + 1'b1;
      if (smp_end) smp_cnt <= sym_end ? '0 : smp_cnt + 1'b1;
      if (sym_end) begin
        sym_cnt <= last_sym ? '0 : sym_cnt + 18'd1;
        case (state)
          PRE:     pre_sr <= pre_sr << 2;
          HDR:     hdr_sr <= hdr_sr << 2;
          PAY:     if (!need_load) shreg <= shreg << 2;
          default: ;
        endcase
      end
      if (take) begin
        hold_data <= i_byte;
        hold_vld  <= 1'b1;
        fetched   <= fetched + 16'd1;
      end
      if (need_load && hold_vld) begin
        shreg    <= hold_data;
        hold_vld <= 1'b0;
      end
    end
  end

  assign o_busy      = busy;
  assign o_done      = done;
  assign o_underrun  = underrun;
  assign o_toDAC_vld = busy && (clk_cnt == '0);
  assign o_toDAC_i   = (busy && smp_cnt == '0) ? (bits[1] ? -AMP : AMP) : '0;
  assign o_toDAC_q   = (busy && smp_cnt == '0) ? (bits[0] ? -AMP : AMP) : '0;

endmodule

// File: tb/tb_tx_framer_qpsk.sv
// Self-checking bench for tx_framer_qpsk: frames are compared cycle by cycle against
// a model derived from the frame bit list and the sample/symbol timing arithmetic.
module tb_tx_framer_qpsk;

  localparam int SPS      = 2;
  localparam int CPS      = 2;
  localparam int SCLK     = SPS * CPS;
  localparam int PRE_SYMS = 32;
  localparam logic signed [15:0] AMP = 16'sd1448;

  logic               i_clk = 1'b0;
  logic               i_rst, i_start, i_byte_vld;
  logic [15:0]        i_len;
  logic [7:0]         i_byte;
  logic               o_byte_rdy, o_toDAC_vld, o_busy, o_done, o_underrun;
  logic signed [15:0] o_toDAC_i, o_toDAC_q;

  always #5 i_clk = ~i_clk;

  tx_framer_qpsk #(.SPS(SPS), .CLK_PER_S(CPS), .PRE_BITS(64),
                   .PREAMBLE(64'hA5F0_3C96_0FF0_5AC3), .AMP(AMP)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len),
    .i_byte(i_byte), .i_byte_vld(i_byte_vld), .o_byte_rdy(o_byte_rdy),
    .o_toDAC_i(o_toDAC_i), .o_toDAC_q(o_toDAC_q), .o_toDAC_vld(o_toDAC_vld),
    .o_busy(o_busy), .o_done(o_done), .o_underrun(o_underrun)
  );

  typedef struct packed {
    logic               vld;
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic               busy;
    logic               done;
    logic               und;
    logic               rdy;
  } obs_t;

  obs_t       rec[$];
  logic [7:0] byte_q[$];
  int         start_at[$];
  bit         frame_bits[$];
  int         byte_limit;
  int         hs_count;
  bit         vld_gaps;
  int         checks = 0;
  int         failures = 0;
  logic [63:0] pre_pat = 64'hA5F0_3C96_0FF0_5AC3;

  function automatic int frame_clks(input int len);
    return (PRE_SYMS + 8 + 4 * len) * SCLK;
  endfunction

  task automatic build_bits(input int len);
    logic [15:0] l;
    logic [7:0]  b;
    l = 16'(len);
    frame_bits.delete();
    for (int i = 63; i >= 0; i--) frame_bits.push_back(pre_pat[i]);
    for (int i = 15; i >= 0; i--) frame_bits.push_back(l[i]);
    foreach (byte_q[n]) begin
      b = byte_q[n];
      for (int i = 7; i >= 0; i--) frame_bits.push_back(b[i]);
    end
  endtask

  // Expected outputs at cycle c after the accepted start (start sampled at cycle 0).
  function automatic obs_t model(input int c, input int end_cyc, input bit complete);
    obs_t e;
    int   k, s;
    bit   active;
    e      = '0;
    active = (c >= 1) && (c <= end_cyc);
    k      = (c - 1) / CPS;
    s      = k / SPS;
    e.busy = active;
    e.vld  = active && ((c - 1) % CPS == 0);
    if (active && (k % SPS == 0)) begin
      e.i = frame_bits[2*s]     ? -AMP : AMP;
      e.q = frame_bits[2*s + 1] ? -AMP : AMP;
    end
    e.done = complete && (c == end_cyc);
    e.und  = !complete && (c == end_cyc);
    return e;
  endfunction

  // Issues a start with the given length, then records ncyc cycles of outputs while
  // feeding byte_q[0..byte_limit-1] and pulsing (ignored-length) starts at start_at.
  task automatic run_frame(input logic [15:0] len, input int ncyc);
    int   idx;
    bit   prev_low;
    logic hs;
    obs_t o;
    rec.delete();
    hs_count = 0;
    idx = 0;
    prev_low = 1'b0;
    i_start = 1'b1;
    i_len = len;
    i_byte_vld = 1'b0;
    @(posedge i_clk); #1;
    for (int c = 1; c <= ncyc; c++) begin
      i_start = 1'b0;
      foreach (start_at[j]) if (start_at[j] == c) begin
        i_start = 1'b1;
        i_len = 16'd5;
      end
      if (idx < byte_limit) begin
        i_byte_vld = !vld_gaps || prev_low || ($urandom_range(0, 3) != 0);
        prev_low = !i_byte_vld;
      end else begin
        i_byte_vld = 1'b0;
      end
      i_byte = (idx < byte_q.size()) ? byte_q[idx] : 8'h00;
      @(negedge i_clk);
      o.vld = o_toDAC_vld; o.i = o_toDAC_i; o.q = o_toDAC_q; o.busy = o_busy;
      o.done = o_done; o.und = o_underrun; o.rdy = o_byte_rdy;
      rec.push_back(o);
      hs = i_byte_vld && o_byte_rdy;
      @(posedge i_clk); #1;
      if (hs) begin
        idx++;
        hs_count++;
      end
    end
    i_start = 1'b0;
    i_byte_vld = 1'b0;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_start = 1'b1; i_len = 16'd5;
    repeat (3) @(posedge i_clk);
    #1; i_rst = 1'b0; i_start = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge i_clk);
      checks++;
      if ({o_toDAC_vld, o_busy, o_done, o_underrun, o_byte_rdy} !== 5'b0 ||
          o_toDAC_i !== 16'sd0 || o_toDAC_q !== 16'sd0) begin
        failures++;
        $display("FAIL reset_idle n=%0d got vld=%b busy=%b done=%b und=%b rdy=%b i=%0d q=%0d want all 0",
                 n, o_toDAC_vld, o_busy, o_done, o_underrun, o_byte_rdy, o_toDAC_i, o_toDAC_q);
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_empty_frame;
    int   n, dones, strobes;
    obs_t e, o;
    n = frame_clks(0);
    byte_q.delete(); byte_limit = 0; start_at.delete(); vld_gaps = 1'b0;
    build_bits(0);
    run_frame(16'd0, n + 8);
    dones = 0; strobes = 0;
    for (int c = 1; c <= rec.size(); c++) begin
      e = model(c, n, 1'b1); o = rec[c-1];
      dones += int'(o.done); strobes += int'(o.vld);
      checks++;
      if (o.vld !== e.vld || o.i !== e.i || o.q !== e.q || o.busy !== e.busy || o.done !== e.done || o.und !== e.und) begin
        failures++;
        $display("FAIL empty_frame cyc=%0d got vld=%b i=%0d q=%0d busy=%b done=%b und=%b want vld=%b i=%0d q=%0d busy=%b done=%b und=%b",
                 c, o.vld, o.i, o.q, o.busy, o.done, o.und, e.vld, e.i, e.q, e.busy, e.done, e.und);
      end
      if (c <= PRE_SYMS * SCLK || c > n) begin
        checks++;
        if (o.rdy !== 1'b0) begin failures++; $display("FAIL empty_frame_rdy cyc=%0d got %b want 0", c, o.rdy); end
      end
    end
    checks++;
    if (rec[0].i !== -16'sd1448 || rec[0].q !== 16'sd1448) begin
      failures++; $display("FAIL first_symbol got i=%0d q=%0d want i=-1448 q=1448", rec[0].i, rec[0].q);
    end
    checks++;
    if (dones != 1 || rec[159].done !== 1'b1) begin
      failures++; $display("FAIL empty_done got count=%0d at160=%b want count=1 at160=1", dones, rec[159].done);
    end
    checks++;
    if (strobes != 80) begin failures++; $display("FAIL empty_strobes got %0d want 80", strobes); end
  endtask

  task automatic test_fixed_payload;
    int   n;
    obs_t e, o;
    n = frame_clks(2);
    byte_q = '{8'h1B, 8'hE4}; byte_limit = 2; start_at.delete(); vld_gaps = 1'b0;
    build_bits(2);
    run_frame(16'd2, n + 8);
    for (int c = 1; c <= rec.size(); c++) begin
      e = model(c, n, 1'b1); o = rec[c-1];
      checks++;
      if (o.vld !== e.vld || o.i !== e.i || o.q !== e.q || o.busy !== e.busy || o.done !== e.done || o.und !== e.und) begin
        failures++;
        $display("FAIL fixed_payload cyc=%0d got vld=%b i=%0d q=%0d busy=%b done=%b und=%b want vld=%b i=%0d q=%0d busy=%b done=%b und=%b",
                 c, o.vld, o.i, o.q, o.busy, o.done, o.und, e.vld, e.i, e.q, e.busy, e.done, e.und);
      end
      if (c <= PRE_SYMS * SCLK || c > n) begin
        checks++;
        if (o.rdy !== 1'b0) begin failures++; $display("FAIL fixed_rdy cyc=%0d got %b want 0", c, o.rdy); end
      end
    end
    // Payload symbol 0 is (+,+) and symbol 3 is (-,-) for byte 8'h1B.
    checks++;
    if (rec[160].i !== AMP || rec[160].q !== AMP || rec[172].i !== -AMP || rec[172].q !== -AMP) begin
      failures++;
      $display("FAIL fixed_symbols got (%0d,%0d) (%0d,%0d) want (1448,1448) (-1448,-1448)",
               rec[160].i, rec[160].q, rec[172].i, rec[172].q);
    end
    checks++;
    if (hs_count != 2) begin failures++; $display("FAIL fixed_handshakes got %0d want 2", hs_count); end
  endtask

  task automatic test_random_frames;
    int   n, len;
    obs_t e, o;
    for (int f = 0; f < 3; f++) begin
      len = $urandom_range(1, 6);
      byte_q.delete();
      for (int b = 0; b < len; b++) byte_q.push_back(8'($urandom_range(0, 255)));
      byte_limit = len; start_at.delete(); vld_gaps = 1'b1;
      n = frame_clks(len);
      build_bits(len);
      run_frame(16'(len), n + 6);
      for (int c = 1; c <= rec.size(); c++) begin
        e = model(c, n, 1'b1); o = rec[c-1];
        checks++;
        if (o.vld !== e.vld || o.i !== e.i || o.q !== e.q || o.busy !== e.busy || o.done !== e.done || o.und !== e.und) begin
          failures++;
          $display("FAIL random_frame f=%0d len=%0d cyc=%0d got vld=%b i=%0d q=%0d busy=%b done=%b und=%b want vld=%b i=%0d q=%0d busy=%b done=%b und=%b",
                   f, len, c, o.vld, o.i, o.q, o.busy, o.done, o.und, e.vld, e.i, e.q, e.busy, e.done, e.und);
        end
        if (c <= PRE_SYMS * SCLK || c > n) begin
          checks++;
          if (o.rdy !== 1'b0) begin failures++; $display("FAIL random_rdy f=%0d cyc=%0d got %b want 0", f, c, o.rdy); end
        end
      end
      checks++;
      if (hs_count != len) begin failures++; $display("FAIL random_handshakes f=%0d got %0d want %0d", f, hs_count, len); end
    end
  endtask

  task automatic test_underrun;
    int   a, unds, dones;
    obs_t e, o;
    byte_q.delete();
    for (int b = 0; b < 3; b++) byte_q.push_back(8'($urandom_range(0, 255)));
    byte_limit = 2; start_at.delete(); vld_gaps = 1'b0;
    a = (PRE_SYMS + 8 + 4 * 2) * SCLK;
    build_bits(3);
    run_frame(16'd3, a + 10);
    unds = 0; dones = 0;
    for (int c = 1; c <= rec.size(); c++) begin
      e = model(c, a, 1'b0); o = rec[c-1];
      unds += int'(o.und); dones += int'(o.done);
      checks++;
      if (o.vld !== e.vld || o.i !== e.i || o.q !== e.q || o.busy !== e.busy || o.done !== e.done || o.und !== e.und) begin
        failures++;
        $display("FAIL underrun_frame cyc=%0d got vld=%b i=%0d q=%0d busy=%b done=%b und=%b want vld=%b i=%0d q=%0d busy=%b done=%b und=%b",
                 c, o.vld, o.i, o.q, o.busy, o.done, o.und, e.vld, e.i, e.q, e.busy, e.done, e.und);
      end
      if (c <= PRE_SYMS * SCLK || c > a) begin
        checks++;
        if (o.rdy !== 1'b0) begin failures++; $display("FAIL underrun_rdy cyc=%0d got %b want 0", c, o.rdy); end
      end
    end
    checks++;
    if (unds != 1 || dones != 0 || hs_count != 2) begin
      failures++;
      $display("FAIL underrun_counts got und=%0d done=%0d hs=%0d want und=1 done=0 hs=2", unds, dones, hs_count);
    end
  endtask

  task automatic test_reset_mid;
    int   n;
    obs_t e, o;
    byte_q = '{8'h3C, 8'h81}; byte_limit = 2; start_at.delete(); vld_gaps = 1'b0;
    build_bits(2);
    run_frame(16'd2, 170);
    checks++;
    if (rec[169].busy !== 1'b1) begin failures++; $display("FAIL mid_busy got %b want 1", rec[169].busy); end
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_busy, o_toDAC_vld, o_done, o_underrun} !== 4'b0 || o_toDAC_i !== 16'sd0 || o_toDAC_q !== 16'sd0) begin
      failures++;
      $display("FAIL mid_reset got busy=%b vld=%b done=%b und=%b i=%0d q=%0d want all 0",
               o_busy, o_toDAC_vld, o_done, o_underrun, o_toDAC_i, o_toDAC_q);
    end
    @(posedge i_clk); #1;
    byte_q = '{8'($urandom_range(0, 255))}; byte_limit = 1;
    n = frame_clks(1);
    build_bits(1);
    run_frame(16'd1, n + 6);
    for (int c = 1; c <= rec.size(); c++) begin
      e = model(c, n, 1'b1); o = rec[c-1];
      checks++;
      if (o.vld !== e.vld || o.i !== e.i || o.q !== e.q || o.busy !== e.busy || o.done !== e.done || o.und !== e.und) begin
        failures++;
        $display("FAIL restart_frame cyc=%0d got vld=%b i=%0d q=%0d busy=%b done=%b und=%b want vld=%b i=%0d q=%0d busy=%b done=%b und=%b",
                 c, o.vld, o.i, o.q, o.busy, o.done, o.und, e.vld, e.i, e.q, e.busy, e.done, e.und);
      end
    end
    checks++;
    if (hs_count != 1) begin failures++; $display("FAIL restart_handshakes got %0d want 1", hs_count); end
  endtask

  task automatic test_ignored_start;
    int   n;
    obs_t e, o;
    byte_q = '{8'($urandom_range(0, 255)), 8'h55, 8'hAA}; byte_limit = 3; vld_gaps = 1'b0;
    n = frame_clks(1);
    start_at = '{20, 150, n, n + 1};
    build_bits(1);
    byte_q = '{byte_q[0]};
    byte_limit = 1;
    run_frame(16'd1, n + 1);
    for (int c = 1; c <= rec.size(); c++) begin
      e = model(c, n, 1'b1); o = rec[c-1];
      checks++;
      if (o.vld !== e.vld || o.i !== e.i || o.q !== e.q || o.busy !== e.busy || o.done !== e.done || o.und !== e.und) begin
        failures++;
        $display("FAIL ignored_start cyc=%0d got vld=%b i=%0d q=%0d busy=%b done=%b und=%b want vld=%b i=%0d q=%0d busy=%b done=%b und=%b",
                 c, o.vld, o.i, o.q, o.busy, o.done, o.und, e.vld, e.i, e.q, e.busy, e.done, e.und);
      end
    end
    checks++;
    if (hs_count != 1) begin failures++; $display("FAIL ignored_handshakes got %0d want 1", hs_count); end
    // The start issued the cycle after o_done must be accepted.
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b1 || o_toDAC_vld !== 1'b1) begin
      failures++; $display("FAIL start_after_done got busy=%b vld=%b want busy=1 vld=1", o_busy, o_toDAC_vld);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    start_at.delete();
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_len = '0; i_byte = '0; i_byte_vld = 1'b0;
    byte_limit = 0; hs_count = 0; vld_gaps = 1'b0;
    test_reset();
    test_empty_frame();
    test_fixed_payload();
    test_random_frames();
    test_underrun();
    test_reset_mid();
    test_ignored_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
